// File: rtl/fifo_grace.sv
// First-word fall-through FIFO whose full flag drops GRACE_PERIOD entries early,
// so writes still in flight from registered producers land in the reserve.
module fifo_grace #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int DEPTH        = 32,
    parameter int GRACE_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   FULL_AT  = (ADDR_WIDTH + 1)'(DEPTH - GRACE_PERIOD);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic not_empty;
    logic wr_req;
    logic rd;
    logic wr;

    assign not_empty = (count_q != '0);
    assign wr_req    = if_write & if_write_ce;
    assign rd        = if_read & if_read_ce & not_empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign wr        = wr_req & ((count_q < DEPTH_C) | rd);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (wr_req && !wr) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; the count masks stale contents.
    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            mem_q[wr_ptr_q] <= if_din;
        end
    end

    assign if_empty_n  = not_empty;
    assign if_full_n   = (count_q < FULL_AT);
    assign if_count    = count_q;
    assign if_overflow = overflow_q;
    assign if_dout     = not_empty ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fifo_grace.sv
// Bench for fifo_grace: a DEPTH=4/GRACE=1 instance and a DEPTH=3/GRACE=0 instance,
// each shadowed by a queue model checked every cycle plus directed literal checks.
module tb_fifo_grace;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: DEPTH=4, GRACE=1
    logic       w4 = 0, wce4 = 1, r4 = 0, rce4 = 1;
    logic [7:0] d4 = 0;
    logic       full4, empty4, ovf4;
    logic [7:0] dout4;
    logic [2:0] cnt4;

    // Instance B: DEPTH=3, GRACE=0
    logic       w3 = 0, wce3 = 1, r3 = 0, rce3 = 1;
    logic [7:0] d3 = 0;
    logic       full3, empty3, ovf3;
    logic [7:0] dout3;
    logic [2:0] cnt3;

    fifo_grace #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .GRACE_PERIOD(1)) u4 (
        .clk(clk), .reset(rst),
        .if_full_n(full4), .if_write_ce(wce4), .if_write(w4), .if_din(d4),
        .if_empty_n(empty4), .if_read_ce(rce4), .if_read(r4), .if_dout(dout4),
        .if_count(cnt4), .if_overflow(ovf4)
    );

    fifo_grace #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(3), .GRACE_PERIOD(0)) u3 (
        .clk(clk), .reset(rst),
        .if_full_n(full3), .if_write_ce(wce3), .if_write(w3), .if_din(d3),
        .if_empty_n(empty3), .if_read_ce(rce3), .if_read(r3), .if_dout(dout3),
        .if_count(cnt3), .if_overflow(ovf3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain queues following the acceptance rules.
    logic [7:0] q4[$];
    logic [7:0] q3[$];
    bit         m_ovf4 = 0, m_ovf3 = 0;
    bit         started = 0;

    always @(posedge clk) begin
        bit rd, wr;
        if (rst) begin
            q4.delete();
            q3.delete();
            m_ovf4 = 0;
            m_ovf3 = 0;
        end else begin
            rd = r4 && rce4 && q4.size() > 0;
            wr = w4 && wce4 && (q4.size() < 4 || rd);
            if (w4 && wce4 && !wr) m_ovf4 = 1;
            if (rd) void'(q4.pop_front());
            if (wr) q4.push_back(d4);

            rd = r3 && rce3 && q3.size() > 0;
            wr = w3 && wce3 && (q3.size() < 3 || rd);
            if (w3 && wce3 && !wr) m_ovf3 = 1;
            if (rd) void'(q3.pop_front());
            if (wr) q3.push_back(d3);
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("A.count", int'(cnt4), q4.size());
            chk("A.empty_n", int'(empty4), int'(q4.size() > 0));
            chk("A.full_n", int'(full4), int'(q4.size() < 3));
            chk("A.dout", int'(dout4), q4.size() > 0 ? int'(q4[0]) : 0);
            chk("A.overflow", int'(ovf4), int'(m_ovf4));
            chk("B.count", int'(cnt3), q3.size());
            chk("B.empty_n", int'(empty3), int'(q3.size() > 0));
            chk("B.full_n", int'(full3), int'(q3.size() < 3));
            chk("B.dout", int'(dout3), q3.size() > 0 ? int'(q3[0]) : 0);
            chk("B.overflow", int'(ovf3), int'(m_ovf3));
            chk("B.count_max", int'(cnt3 <= 3), 1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_pop[4];

        rst = 1;
        cyc();
        rst = 0;
        chk("rst.count", int'(cnt4), 0);
        chk("rst.empty_n", int'(empty4), 0);
        chk("rst.full_n", int'(full4), 1);
        chk("rst.dout", int'(dout4), 0);
        chk("rst.overflow", int'(ovf4), 0);

        // Fill to the grace threshold
        w4 = 1; d4 = 8'h11; cyc();
        d4 = 8'h22; cyc();
        chk("fill2.full_n", int'(full4), 1);
        d4 = 8'h33; cyc();
        w4 = 0;
        chk("fill3.full_n", int'(full4), 0);
        chk("fill3.count", int'(cnt4), 3);
        chk("fill3.dout", int'(dout4), 8'h11);
        chk("fill3.overflow", int'(ovf4), 0);

        // Grace entry accepted, then a dropped write
        w4 = 1; d4 = 8'h44; cyc();
        chk("grace.count", int'(cnt4), 4);
        d4 = 8'h55; cyc();
        w4 = 0;
        chk("drop.count", int'(cnt4), 4);
        chk("drop.overflow", int'(ovf4), 1);

        exp_pop = '{8'h11, 8'h22, 8'h33, 8'h44};
        r4 = 1;
        for (int i = 0; i < 4; i++) begin
            chk("pop.data", int'(dout4), int'(exp_pop[i]));
            cyc();
        end
        r4 = 0;
        chk("drain.empty_n", int'(empty4), 0);
        chk("drain.dout", int'(dout4), 0);
        chk("drain.overflow", int'(ovf4), 1);

        r4 = 1; cyc(); r4 = 0;
        chk("rd_empty.count", int'(cnt4), 0);

        // Simultaneous read/write at full
        rst = 1; cyc(); rst = 0;
        w4 = 1;
        for (int i = 0; i < 4; i++) begin
            d4 = 8'hA1 + 8'(i);
            cyc();
        end
        d4 = 8'h66; r4 = 1;
        chk("rw_full.head", int'(dout4), 8'hA1);
        cyc();
        w4 = 0; r4 = 0;
        chk("rw_full.count", int'(cnt4), 4);
        chk("rw_full.overflow", int'(ovf4), 0);
        exp_pop = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
        r4 = 1;
        for (int i = 0; i < 4; i++) begin
            chk("rw_pop.data", int'(dout4), int'(exp_pop[i]));
            cyc();
        end
        r4 = 0;

        // Clock-enable gating
        wce4 = 0; w4 = 1; d4 = 8'h77; cyc();
        w4 = 0; wce4 = 1;
        chk("wce.count", int'(cnt4), 0);
        chk("wce.overflow", int'(ovf4), 0);
        w4 = 1; d4 = 8'h88; cyc(); w4 = 0;
        rce4 = 0; r4 = 1; cyc(); r4 = 0; rce4 = 1;
        chk("rce.count", int'(cnt4), 1);
        chk("rce.dout", int'(dout4), 8'h88);
        w4 = 1;
        for (int i = 0; i < 3; i++) begin
            d4 = 8'h90 + 8'(i);
            cyc();
        end
        wce4 = 0; d4 = 8'hEE; cyc();
        w4 = 0; wce4 = 1;
        chk("wce_full.count", int'(cnt4), 4);
        chk("wce_full.overflow", int'(ovf4), 0);

        // Reset with a write pending
        rst = 1; cyc(); rst = 0;
        w4 = 1;
        for (int i = 1; i <= 3; i++) begin
            d4 = 8'(i);
            cyc();
        end
        rst = 1; d4 = 8'hCC; cyc();
        rst = 0; w4 = 0;
        chk("rstw.count", int'(cnt4), 0);
        chk("rstw.empty_n", int'(empty4), 0);
        chk("rstw.full_n", int'(full4), 1);
        chk("rstw.overflow", int'(ovf4), 0);
        chk("rstw.dout", int'(dout4), 0);

        // DEPTH=3, GRACE=0: wrap at 2, streaming through a full FIFO
        begin
            int k = 1;
            w3 = 1;
            for (int i = 1; i <= 3; i++) begin
                d3 = 8'(i);
                cyc();
            end
            chk("b.full_n", int'(full3), 0);
            chk("b.count", int'(cnt3), 3);
            r3 = 1;
            for (int i = 4; i <= 10; i++) begin
                d3 = 8'(i);
                chk("b.order", int'(dout3), k);
                k++;
                cyc();
            end
            w3 = 0;
            for (int i = 0; i < 3; i++) begin
                chk("b.order", int'(dout3), k);
                k++;
                cyc();
            end
            r3 = 0;
            chk("b.drained", int'(empty3), 0);
            chk("b.no_ovf", int'(ovf3), 0);
            w3 = 1;
            for (int i = 0; i < 4; i++) begin
                d3 = 8'hB0 + 8'(i);
                cyc();
            end
            w3 = 0;
            chk("b.drop.count", int'(cnt3), 3);
            chk("b.drop.overflow", int'(ovf3), 1);
            chk("b.drop.head", int'(dout3), 8'hB0);
        end

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
